// File: rtl/video_scanout.sv
// video_scanout: raster timing generator and framebuffer scanout.
// Three-stage pipeline, all stages advancing on pix_ce:
//   stage 0 - h/v counters, sync/visible decode, framebuffer read issue
//   stage 1 - read data returns; control flags for that pixel registered
//   stage 2 - output register (hsync, vsync, de, rgb, frame_start)
// The framebuffer holds one 32-bit word per 4x4 pixel block, with the
// 12-bit colour in the low bits of each word.

module video_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        en,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Per-pixel control flags carried alongside the read through the pipe.
  typedef struct packed {
    logic hs;   // active-low horizontal sync
    logic vs;   // active-low vertical sync
    logic vis;  // pixel inside the visible window
    logic en;   // scanout enable sampled with this pixel
    logic fs;   // first visible pixel of the frame
  } ctrl_t;

  // Idle flags: syncs deasserted, nothing visible, so a restart never
  // emits a partial sync pulse.
  localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, en: 1'b0, fs: 1'b0};

  // ---------------------------------------------------------------- stage 0
  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  ctrl_t         ctrl_s0;
  logic [14:0]   addr_now;
  logic [14:0]   rd_addr_reg;

  // Raster counters: h wraps at line end and carries into v; v wraps at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_ce) begin
      if (h_cnt_reg == H_MAX) begin
        h_cnt_reg <= '0;
        if (v_cnt_reg == V_MAX) begin
          v_cnt_reg <= '0;
        end else begin
          v_cnt_reg <= v_cnt_reg + 1'b1;
        end
      end else begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end
    end
  end

  // Decode the current raster position into control flags.
  always_comb begin
    ctrl_s0     = CTRL_IDLE;
    ctrl_s0.vis = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    ctrl_s0.hs  = !((h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST));
    ctrl_s0.vs  = !((v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST));
    ctrl_s0.en  = en;
    ctrl_s0.fs  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  // One framebuffer word covers a 4x4 block, so both coordinates drop two bits.
  assign addr_now = 15'((v_cnt_reg >> 2) * FB_W) + 15'(h_cnt_reg >> 2);

  // Read strobe is a pure decode of this tick; reset masks it so a held
  // reset never issues reads even while pix_ce is high.
  assign rd_en   = pix_ce & en & ctrl_s0.vis & ~rst;
  assign rd_addr = rd_en ? addr_now : rd_addr_reg;

  // Remember the last issued address so the read port stays quiet between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_reg <= '0;
    end else if (rd_en) begin
      rd_addr_reg <= addr_now;
    end
  end

  // ---------------------------------------------------------------- stage 1
  ctrl_t ctrl_s1_reg;

  // Hold the flags of the pixel whose read is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_s1_reg <= CTRL_IDLE;
    end else if (pix_ce) begin
      ctrl_s1_reg <= ctrl_s0;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic        hsync_reg;
  logic        vsync_reg;
  logic        de_reg;
  logic [11:0] rgb_reg;
  logic        frame_start_reg;

  // Output register: rd_data is already valid (and held) by the next tick.
  // frame_start self-clears every clk so it is a single-clk pulse even
  // when pix_ce is sparse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      de_reg          <= 1'b0;
      rgb_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      if (pix_ce) begin
        hsync_reg       <= ctrl_s1_reg.hs;
        vsync_reg       <= ctrl_s1_reg.vs;
        de_reg          <= ctrl_s1_reg.vis;
        rgb_reg         <= (ctrl_s1_reg.vis && ctrl_s1_reg.en) ? rd_data[11:0] : 12'h000;
        frame_start_reg <= ctrl_s1_reg.fs;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign rgb         = rgb_reg;
  assign frame_start = frame_start_reg;

  // Upper word bits carry no pixel data.
  logic unused_rd_data_hi;
  assign unused_rd_data_hi = ^rd_data[31:12];

endmodule

// File: tb/tb_video_scanout.sv
// Testbench for video_scanout: a shrunken raster (24x17 total) for whole
// frame scenarios plus a default-size instance for a specific pixel probe.
// Expected outputs are queued at each pixel tick and popped one tick later,
// when the DUT's output register shows that pixel.

module tb_video_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int FBW = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic        en = 1'b0;

  // small instance
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  // default-parameter instance
  logic        rd_en_d;
  logic [14:0] rd_addr_d;
  logic [31:0] rd_data_d = '0;
  logic        hsync_d, vsync_d, de_d, frame_start_d;
  logic [11:0] rgb_d;

  always #5 clk = ~clk;

  // Memory models: word content equals its index.
  always @(posedge clk) if (rd_en) rd_data <= {17'd0, rd_addr};
  always @(posedge clk) if (rd_en_d) rd_data_d <= {17'd0, rd_addr_d};

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FB_W(FBW)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  video_scanout dut_full (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
    .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
    .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .rgb(rgb_d), .frame_start(frame_start_d)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fs;
  } out_t;

  out_t        sb[$];
  int          fs_ticks[$];
  int          mh, mv, tick_n;
  logic [14:0] last_addr;
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_low, vs_low, rd_en_high;

  function automatic out_t reset_entry();
    out_t r;
    r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.rgb = 12'h000; r.fs = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; tick_n = 0; last_addr = '0;
    sb.delete();
    fs_ticks.delete();
    sb.push_back(reset_entry());
  endtask

  // One clk with pix_ce = ce. Checks the read port before the edge and
  // either the scoreboard (ce) or output hold (!ce) after it.
  task automatic tick(input logic ce);
    out_t        exp_o, got;
    logic        vis, exp_rden;
    logic [14:0] addr_calc, exp_addr;
    logic [29:0] snap;
    @(negedge clk);
    pix_ce = ce;
    #1;
    vis       = (mh < HA) && (mv < VA);
    exp_rden  = ce & en & vis;
    addr_calc = 15'((mv / 4) * FBW + mh / 4);
    exp_addr  = exp_rden ? addr_calc : last_addr;
    n_checks++;
    if (rd_en !== exp_rden || rd_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL rd_port h=%0d v=%0d: got rd_en=%b rd_addr=%0d, required rd_en=%b rd_addr=%0d",
               mh, mv, rd_en, rd_addr, exp_rden, exp_addr);
    end
    if (rd_en === 1'b1) rd_en_high++;
    snap = {hsync, vsync, de, rgb, rd_addr};
    @(posedge clk);
    #1;
    if (ce) begin
      exp_o.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
      exp_o.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
      exp_o.de  = vis;
      exp_o.rgb = (vis && en) ? addr_calc[11:0] : 12'h000;
      exp_o.fs  = (mh == 0) && (mv == 0);
      sb.push_back(exp_o);
      if (exp_rden) last_addr = exp_addr;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      if (frame_start === 1'b1) fs_ticks.push_back(tick_n);
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      tick_n++;
      if (sb.size() >= 2) begin
        exp_o = sb.pop_front();
        got   = {hsync, vsync, de, rgb, frame_start};
        n_checks++;
        if (got !== exp_o) begin
          n_fail++;
          $display("FAIL scoreboard tick=%0d: got hs=%b vs=%b de=%b rgb=%h fs=%b, required hs=%b vs=%b de=%b rgb=%h fs=%b",
                   tick_n - 1, got.hs, got.vs, got.de, got.rgb, got.fs,
                   exp_o.hs, exp_o.vs, exp_o.de, exp_o.rgb, exp_o.fs);
        end
      end
    end else begin
      n_checks++;
      if ({hsync, vsync, de, rgb, rd_addr} !== snap || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_no_ce: got %h fs=%b, required %h fs=0",
                 {hsync, vsync, de, rgb, rd_addr}, frame_start, snap);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pix_ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; pix_ce = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({hsync, vsync, de, rgb, frame_start, rd_en, rd_addr} !== {3'b110, 12'h000, 2'b00, 15'd0}) begin
        n_fail++;
        $display("FAIL reset_values: got hs=%b vs=%b de=%b rgb=%h fs=%b rd_en=%b rd_addr=%0d, required 1 1 0 000 0 0 0",
                 hsync, vsync, de, rgb, frame_start, rd_en, rd_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0; pix_ce = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({hsync, vsync, de, rgb, frame_start, rd_en, rd_addr} !== {3'b110, 12'h000, 2'b00, 15'd0}) begin
      n_fail++;
      $display("FAIL reset_release_idle: got hs=%b vs=%b de=%b rgb=%h fs=%b rd_en=%b rd_addr=%0d",
               hsync, vsync, de, rgb, frame_start, rd_en, rd_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_speed();
    do_reset();
    en = 1'b1;
    repeat (FRAME) tick(1'b1);
    hs_low = 0; vs_low = 0;
    repeat (FRAME) tick(1'b1);
    n_checks++;
    if (hs_low != VT * HS || vs_low != VS * HT) begin
      n_fail++;
      $display("FAIL sync_widths: got hsync_low=%0d vsync_low=%0d, required %0d %0d",
               hs_low, vs_low, VT * HS, VS * HT);
    end
    $display("test_full_speed done: hsync_low=%0d vsync_low=%0d per frame", hs_low, vs_low);
  endtask

  task automatic test_en_off();
    do_reset();
    en = 1'b0;
    rd_en_high = 0;
    hs_low = 0; vs_low = 0;
    repeat (FRAME + 2) tick(1'b1);
    n_checks++;
    if (rd_en_high != 0) begin
      n_fail++;
      $display("FAIL en_off_no_reads: got %0d rd_en pulses, required 0", rd_en_high);
    end
    $display("test_en_off done: rd_en pulses=%0d", rd_en_high);
  endtask

  task automatic test_slow_ce();
    do_reset();
    en = 1'b1;
    repeat (FRAME + 2) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end
    $display("test_slow_ce done: %0d ticks", tick_n);
  endtask

  task automatic test_en_toggle();
    en = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) en = ~en;
      tick($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
    $display("test_en_toggle done");
  endtask

  task automatic test_mid_reset();
    bit reached = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      tick(1'b1);
      reached = (mv == 8) && (mh == 5);
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL mid_reset_reach: got v=%0d h=%0d, required v=8 h=5", mv, mh);
    end
    @(negedge clk);
    rst = 1'b1; pix_ce = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({hsync, vsync, de, rgb, frame_start, rd_en, rd_addr} !== {3'b110, 12'h000, 2'b00, 15'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: got hs=%b vs=%b de=%b rgb=%h fs=%b rd_en=%b rd_addr=%0d",
               hsync, vsync, de, rgb, frame_start, rd_en, rd_addr);
    end
    @(negedge clk);
    rst = 1'b0; pix_ce = 1'b0;
    model_reset();
    repeat (2 * FRAME + 4) tick(1'b1);
    n_checks++;
    if (fs_ticks.size() < 2) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d pulses, required at least 2", fs_ticks.size());
    end else begin
      n_checks++;
      if (fs_ticks[0] != 1 || fs_ticks[1] - fs_ticks[0] != FRAME) begin
        n_fail++;
        $display("FAIL frame_start_timing: got first=%0d period=%0d, required first=1 period=%0d",
                 fs_ticks[0], fs_ticks[1] - fs_ticks[0], FRAME);
      end
    end
    $display("test_mid_reset done: frame_start pulses=%0d", fs_ticks.size());
  endtask

  task automatic test_pixel_default();
    do_reset();
    en = 1'b1;
    while (tick_n < 9 * 800 + 700 + 2) begin
      tick(1'b1);
      if (tick_n == 9 * 800 + 13 + 2) begin
        n_checks++;
        if (rgb_d !== 12'h143 || de_d !== 1'b1) begin
          n_fail++;
          $display("FAIL pixel_13_9: got rgb=%h de=%b, required rgb=143 de=1", rgb_d, de_d);
        end
      end
      if (tick_n == 9 * 800 + 656 + 2) begin
        n_checks++;
        if (hsync_d !== 1'b0 || de_d !== 1'b0 || rgb_d !== 12'h000) begin
          n_fail++;
          $display("FAIL sync_start_656: got hs=%b de=%b rgb=%h, required 0 0 000", hsync_d, de_d, rgb_d);
        end
      end
      if (tick_n == 9 * 800 + 700 + 2) begin
        n_checks++;
        if (de_d !== 1'b0 || rgb_d !== 12'h000 || hsync_d !== 1'b0) begin
          n_fail++;
          $display("FAIL blank_700_9: got de=%b rgb=%h hs=%b, required 0 000 0", de_d, rgb_d, hsync_d);
        end
      end
    end
    $display("test_pixel_default done: rgb at (13,9) probed");
  endtask

  initial begin
    model_reset();
    hs_low = 0; vs_low = 0; rd_en_high = 0;
    test_reset();
    test_full_speed();
    test_en_off();
    test_slow_ce();
    test_en_toggle();
    test_mid_reset();
    test_pixel_default();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
